mem_arbiter: RTL and testbench

- Shares the single memory port between IFU (instruction fetch, read-only) and LSU (load/store, read/write).
- Sits between the fetch/load-store units and the memory slave in the multi-cycle NPC.
- Allows one outstanding transaction at a time, with round-robin grant on contention.
- A response timeout counter converts a hung slave into an error response to the requester.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU memory port arbiter, one outstanding transaction, round-robin, response timeout
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_valid,
  input  logic            ifu_rsp_ready,
  output logic [DW-1:0]   ifu_rdata,
  output logic            ifu_rsp_err,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_rsp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_rsp_err
);

  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic G_IFU = 1'b0;
  localparam logic G_LSU = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_ERR} state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic [TW-1:0] tcnt;
  logic          gnt_rsp_ready;

  assign gnt_rsp_ready = (grant == G_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= G_IFU;
      last_grant <= G_IFU;
      tcnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // On a tie the master that did not win last time goes first
          if (ifu_req_valid && lsu_req_valid) begin
            grant <= ~last_grant;
            state <= S_REQ;
          end else if (ifu_req_valid) begin
            grant <= G_IFU;
            state <= S_REQ;
          end else if (lsu_req_valid) begin
            grant <= G_LSU;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state <= S_RSP;
            tcnt  <= '0;
          end
        end
        S_RSP: begin
          if (mem_rsp_valid) begin
            if (gnt_rsp_ready) begin
              state      <= S_IDLE;
              last_grant <= grant;
            end
          end else begin
            if ((TIMEOUT != 0) && (tcnt == TW'(TLAST))) state <= S_ERR;
            if (tcnt != '1) tcnt <= tcnt + TW'(1);
          end
        end
        S_ERR: begin
          if (gnt_rsp_ready) begin
            state      <= S_IDLE;
            last_grant <= grant;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    lsu_rdata     = '0;
    ifu_rsp_err   = 1'b0;
    lsu_rsp_err   = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wen       = 1'b0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    mem_rsp_ready = 1'b0;
    case (state)
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (grant == G_LSU) begin
          mem_addr      = lsu_addr;
          mem_wen       = lsu_wen;
          mem_wdata     = lsu_wdata;
          mem_wmask     = lsu_wmask;
          lsu_req_ready = mem_req_ready;
        end else begin
          mem_addr      = ifu_addr;
          ifu_req_ready = mem_req_ready;
        end
      end
      S_RSP: begin
        mem_rsp_ready = gnt_rsp_ready;
        if (grant == G_LSU) begin
          lsu_rsp_valid = mem_rsp_valid;
          lsu_rdata     = mem_rdata;
          lsu_rsp_err   = mem_rsp_err;
        end else begin
          ifu_rsp_valid = mem_rsp_valid;
          ifu_rdata     = mem_rdata;
          ifu_rsp_err   = mem_rsp_err;
        end
      end
      S_ERR: begin
        if (grant == G_LSU) begin
          lsu_rsp_valid = 1'b1;
          lsu_rsp_err   = 1'b1;
        end else begin
          ifu_rsp_valid = 1'b1;
          ifu_rsp_err   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [AW-1:0]   ifu_addr;
  logic [DW-1:0]   ifu_rdata;
  logic            lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_wdata, lsu_rdata;
  logic [DW/8-1:0] lsu_wmask;
  logic            mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
    .mem_rsp_err(mem_rsp_err)
  );

  // Inputs change and outputs are sampled 2ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_rsp_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_rsp_err = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    mem_req_ready = 1; mem_rsp_valid = 1; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    rst = 1;
    tick();
    tick();
    n_tests++;
    if ({mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready});
    end
    drive_idle();
    rst = 0;
    tick();
  endtask

  task automatic test_ifu_only();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
    #1;
    n_tests++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_cycle0_req_valid: got %b expected 0", mem_req_valid);
    end
    tick();
    n_tests++;
    if ({mem_req_valid, ifu_req_ready, lsu_req_ready, mem_wen} !== 4'b1100 || mem_addr !== 32'h8000_0000
        || mem_wmask !== 4'h0) begin
      n_fail++;
      $display("FAIL ifu_cycle1_req: got v/ir/lr/wen=%b addr=%h mask=%h expected 1100 80000000 0",
               {mem_req_valid, ifu_req_ready, lsu_req_ready, mem_wen}, mem_addr, mem_wmask);
    end
    tick();
    ifu_req_valid = 0; mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rdata = 32'h0000_0413; ifu_rsp_ready = 1;
    #1;
    n_tests++;
    if ({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready, lsu_rsp_valid} !== 4'b1010 || ifu_rdata !== 32'h0000_0413) begin
      n_fail++;
      $display("FAIL ifu_cycle2_rsp: got v/err/mrdy/lv=%b rdata=%h expected 1010 00000413",
               {ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready, lsu_rsp_valid}, ifu_rdata);
    end
    tick();
    drive_idle();
    #1;
    n_tests++;
    if ({ifu_rsp_valid, mem_req_valid} !== 2'b00) begin
      n_fail++; $display("FAIL ifu_back_idle: got %b expected 00", {ifu_rsp_valid, mem_req_valid});
    end
  endtask

  task automatic test_back_to_back();
    logic exp_lsu;
    drive_idle();
    rst = 1; tick(); rst = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000;
    mem_req_ready = 1; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    exp_lsu = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, ~exp_lsu}
          || mem_addr !== (exp_lsu ? 32'h8000_2000 : 32'h8000_0100)) begin
        n_fail++;
        $display("FAIL tie_grant_%0d: got lrdy/irdy=%b addr=%h expected lsu=%b", i,
                 {lsu_req_ready, ifu_req_ready}, mem_addr, exp_lsu);
      end
      tick();
      mem_rsp_valid = 1; mem_rdata = 32'h1000 + i;
      #1;
      n_tests++;
      if ({lsu_rsp_valid, ifu_rsp_valid} !== {exp_lsu, ~exp_lsu}) begin
        n_fail++;
        $display("FAIL tie_rsp_%0d: got lv/iv=%b expected lsu=%b", i, {lsu_rsp_valid, ifu_rsp_valid}, exp_lsu);
      end
      tick();
      mem_rsp_valid = 0;
      exp_lsu = ~exp_lsu;
    end
    drive_idle();
  endtask

  task automatic test_lsu_write();
    int pulses = 0;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      #1;
      if (lsu_req_ready) pulses++;
      n_tests++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1
          || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF || lsu_req_ready !== (i == 3)) begin
        n_fail++;
        $display("FAIL lsu_write_req_%0d: got v=%b addr=%h wen=%b wdata=%h mask=%h rdy=%b", i,
                 mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, lsu_req_ready);
      end
      tick();
    end
    lsu_req_valid = 0; mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rdata = '0; lsu_rsp_ready = 1;
    #1;
    n_tests++;
    if (pulses != 1 || {lsu_rsp_valid, lsu_rsp_err, mem_rsp_ready} !== 3'b101 || lsu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL lsu_write_rsp: got pulses=%0d v/err/mrdy=%b rdata=%h expected 1 101 0",
               pulses, {lsu_rsp_valid, lsu_rsp_err, mem_rsp_ready}, lsu_rdata);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_backpressure();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200; mem_req_ready = 1;
    tick();
    tick();
    ifu_req_valid = 0; mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rdata = 32'hCAFE_0001; ifu_rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if ({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready} !== 3'b100 || ifu_rdata !== 32'hCAFE_0001) begin
        n_fail++;
        $display("FAIL backpressure_%0d: got v/err/mrdy=%b rdata=%h expected 100 cafe0001", i,
                 {ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready}, ifu_rdata);
      end
      tick();
    end
    ifu_rsp_ready = 1;
    #1;
    n_tests++;
    if ({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL backpressure_release: got %b expected 101", {ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready});
    end
    tick();
    drive_idle();
    #1;
    n_tests++;
    if (ifu_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_done: got %b expected 0", ifu_rsp_valid);
    end
  endtask

  task automatic test_timeout();
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; mem_req_ready = 1;
    tick();
    tick();
    lsu_req_valid = 0; mem_req_ready = 0; mem_rdata = 32'h5555_AAAA; lsu_rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (lsu_rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait_%0d: got rsp_valid=%b expected 0", i, lsu_rsp_valid);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      lsu_rsp_ready = (i == 1);
      #1;
      n_tests++;
      if ({lsu_rsp_valid, lsu_rsp_err, mem_rsp_ready, ifu_rsp_valid} !== 4'b1100 || lsu_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL timeout_err_%0d: got v/err/mrdy/iv=%b rdata=%h expected 1100 0", i,
                 {lsu_rsp_valid, lsu_rsp_err, mem_rsp_ready, ifu_rsp_valid}, lsu_rdata);
      end
      tick();
    end
    drive_idle();
    #1;
    n_tests++;
    if ({lsu_rsp_valid, lsu_rsp_err} !== 2'b00) begin
      n_fail++; $display("FAIL timeout_idle: got %b expected 00", {lsu_rsp_valid, lsu_rsp_err});
    end
  endtask

  task automatic test_reset_in_rsp();
    // last_grant is LSU here, so only a real reset hands the next tie to LSU
    lsu_req_valid = 1; lsu_addr = 32'h8000_4000; mem_req_ready = 1;
    tick();
    tick();
    lsu_req_valid = 0;
    mem_rsp_valid = 1; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    ifu_req_valid = 1; lsu_req_valid = 1;
    rst = 1;
    tick();
    n_tests++;
    if ({mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_in_rsp: got %b expected 000000",
               {mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready});
    end
    rst = 0; mem_rsp_valid = 0;
    ifu_addr = 32'h8000_0300; lsu_addr = 32'h8000_5000;
    tick();
    n_tests++;
    if ({lsu_req_ready, ifu_req_ready} !== 2'b10 || mem_addr !== 32'h8000_5000) begin
      n_fail++;
      $display("FAIL post_reset_tie: got lrdy/irdy=%b addr=%h expected 10 80005000",
               {lsu_req_ready, ifu_req_ready}, mem_addr);
    end
    tick();
    drive_idle();
    mem_rsp_valid = 1; lsu_rsp_ready = 1;
    tick();
    drive_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_ifu_only();
    test_back_to_back();
    test_lsu_write();
    test_backpressure();
    test_timeout();
    test_reset_in_rsp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
